// File: rtl/demux1hot_reg_if.sv
// demux1hot_reg_if
//   Bundles the producer-side stream, the NOUT consumer lanes and the error
//   reporting of demux1hot_reg into one interface.
//
//   Ports (signals):
//     in_valid  / in_ready  / in_data / in_sel   producer stream + one-hot select
//     out_valid / out_ready / out_data           per-lane streams, lane i at
//                                                out_data[i*WIDTH +: WIDTH]
//     err / err_cnt                              illegal-select pulse and count
//
//   Handshake: a beat moves on a rising clk edge exactly when valid and ready
//   are both 1 on that edge; valid must not depend on ready, ready may depend
//   on valid-side qualifiers (in_sel) and on downstream ready.
//
//   Modports: master = producer/consumer side (testbench), slave = the demux.
interface demux1hot_reg_if #(
    parameter int WIDTH  = 8,
    parameter int NOUT   = 8,
    parameter int ECNT_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_data;
    logic [NOUT-1:0]         in_sel;
    logic [NOUT-1:0]         out_valid;
    logic [NOUT-1:0]         out_ready;
    logic [NOUT*WIDTH-1:0]   out_data;
    logic                    err;
    logic [ECNT_W-1:0]       err_cnt;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, err, err_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, err, err_cnt
    );
endinterface

// File: rtl/demux1hot_reg.sv
// demux1hot_reg
//   Registered 1-to-NOUT one-hot demultiplexer. Each beat carries a one-hot
//   lane select; the beat is written into that lane's one-entry holding
//   register so lanes drain independently of each other.
//
//   Ports:
//     clk    rising-edge clock for all state
//     rst_n  synchronous active-low reset
//     bus    demux1hot_reg_if.slave (stream in, NOUT lanes out, err/err_cnt)
//
//   Parameters WIDTH/NOUT/ECNT_W must match those of the connected interface.
//
//   Optional build macro DEMUX1HOT_TRUST_SELECT_EN:
//     defined   -> any nonzero select is legal, lowest set bit picks the lane
//     undefined -> only exact one-hot selects are legal
//   Illegal selects are always accepted and dropped, pulse err and bump the
//   saturating err_cnt.
module demux1hot_reg #(
    parameter int WIDTH  = 8,
    parameter int NOUT   = 8,
    parameter int ECNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux1hot_reg_if.slave       bus
);
    localparam int              IDX_W   = $clog2(NOUT);
    localparam logic [NOUT-1:0] SEL_ONE = NOUT'(1);

    logic [NOUT-1:0]             full_q,    full_d;
    logic [NOUT-1:0][WIDTH-1:0]  data_q,    data_d;
    logic                        err_q,     err_d;
    logic [ECNT_W-1:0]           err_cnt_q, err_cnt_d;

    logic                        sel_legal;
    logic [IDX_W-1:0]            sel_idx;
    logic                        in_ready;
    logic                        accept;

    // Select decode. Scanning from the top down leaves the lowest set bit in
    // sel_idx, which is the lane for a one-hot select and the priority pick
    // when multi-bit selects are trusted.
    always_comb begin
        sel_idx = '0;
        for (int i = NOUT - 1; i >= 0; i--) begin
            if (bus.in_sel[i]) sel_idx = IDX_W'(i);
        end
`ifdef DEMUX1HOT_TRUST_SELECT_EN
        sel_legal = |bus.in_sel;
`else
        // x & (x-1) clears the lowest set bit; zero result means at most one.
        sel_legal = (bus.in_sel != '0) &&
                    ((bus.in_sel & (bus.in_sel - SEL_ONE)) == '0);
`endif
    end

    // The target lane can take a beat if it is empty or being drained this
    // cycle (out_ready passes straight through). Illegal beats are always
    // swallowed so a bad select can never stall the producer.
    always_comb begin
        in_ready = 1'b1;
        if (sel_legal) begin
            in_ready = !full_q[sel_idx] | bus.out_ready[sel_idx];
        end
    end

    assign accept = bus.in_valid & in_ready;

    always_comb begin
        full_d    = full_q;
        data_d    = data_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        for (int i = 0; i < NOUT; i++) begin
            if (full_q[i] & bus.out_ready[i]) full_d[i] = 1'b0;
            // A load on the same edge as a drain wins: lane stays full.
            if (accept && sel_legal && (sel_idx == IDX_W'(i))) begin
                full_d[i] = 1'b1;
                data_d[i] = bus.in_data;
            end
        end

        if (accept && !sel_legal) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ECNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q    <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            full_q    <= full_d;
            data_q    <= data_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = full_q;
    assign bus.out_data  = data_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: doc/demux1hot_reg.md
Name: demux1hot_reg

Overview:
- Registered 1-to-NOUT one-hot demultiplexer; the distribution-side counterpart of the one-hot mux library blocks.
- Routes one valid/ready input stream to one of NOUT output lanes, selected by a one-hot select that travels with each beat.
- Each lane has a one-entry holding register, so lanes drain independently.
- Sits between a single producer and NOUT consumers, e.g. issue-to-unit dispatch.

Parameters:
- WIDTH, 8, data width per beat.
- NOUT, 8, number of output lanes (>=2).
- ECNT_W, 8, width of the saturating illegal-select counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  input beat present
- in_ready  output  1  input beat accepted when in_valid & in_ready
- in_data  input  WIDTH  input payload
- in_sel  input  NOUT  one-hot lane select, qualified by in_valid
- out_valid  output  NOUT  per-lane beat present
- out_ready  input  NOUT  per-lane consumer ready
- out_data  output  NOUT*WIDTH  lane i payload at bits [i*WIDTH +: WIDTH]
- err  output  1  one-cycle pulse, illegal select consumed
- err_cnt  output  ECNT_W  count of illegal selects, saturating

Behaviour:
- Reset (rst_n=0 at a clk edge): all lane full flags 0, all lane data registers 0, err 0, err_cnt 0.
  - out_valid is 0 on the first cycle after reset.
  - Any beat presented during a reset cycle is discarded.
  - A reset mid-stream drops every held beat.
- Lane state: full[i], data[i].
  - out_valid[i] = full[i]; out_data lane i = data[i], driven from registers only.
- Select legality:
  - Without the macro, a select is legal iff in_sel has exactly one bit set.
  - A legal select targets lane k, the index of that set bit.
- in_ready (combinational):
  - Legal select: in_ready = !full[k] | out_ready[k]. This is a pass-through path from out_ready to in_ready.
  - Illegal select: in_ready = 1 (beat is consumed and dropped).
  - in_ready is valid whenever in_sel is stable; in_valid=0 has no side effects.
- Accept with a legal select: on the clk edge, data[k] <= in_data and full[k] <= 1. Latency is 1 cycle, input to out_valid[k].
- Drain: if full[i] & out_ready[i], full[i] <= 0 unless lane i is loaded in the same cycle.
- Simultaneous load and drain of the same lane: full stays 1 and data is replaced. Full throughput is one beat per cycle per lane.
- Other lanes hold their contents and drain independently. Multiple lanes may be valid simultaneously.
- Accept with an illegal select (including in_sel=0):
  - No lane state changes.
  - err = 1 on the next cycle only.
  - err_cnt increments by 1 and saturates at 2^ECNT_W-1; it never wraps.
- Back-to-back illegal selects: err stays 1 for each consecutive cycle and err_cnt increments each cycle.
- out_data for an empty lane keeps its last value. It is not zeroed and must not be relied upon.

Optional Feature:
- Macro: DEMUX1HOT_TRUST_SELECT_EN.
- Defined:
  - Any nonzero in_sel is legal; the lowest set bit selects lane k (priority decode).
  - Only in_sel=0 is illegal and follows the illegal path: consumed, err pulse, err_cnt increments.
- Undefined: the exact-one-hot check above applies; multi-bit selects are illegal.

Test Plan:
- Reset then single beat: in_data=0xA5, in_sel=8'b00000100, in_valid=1 for one cycle, out_ready=0 -> next cycle out_valid=8'b00000100, lane 2 data=0xA5, in_ready for a lane-2 select =0.
- Backpressure and pass-through on lane 2: lane 2 full and out_ready[2]=0 -> in_ready=0, data holds. Raise out_ready[2] with new beat 0x3C to lane 2 -> same-edge drain+load, lane 2 still valid with 0x3C.
- Independent lanes: beats 0x11 -> lane 0, then 0x22 -> lane 7, all out_ready=0 -> out_valid=8'b10000001 with correct data per lane. Drain lane 7 only -> out_valid=8'b00000001.
- Illegal select without the macro: in_sel=8'b00000110, in_valid=1 -> in_ready=1, no lane changes, err=1 for one cycle, err_cnt=1. With the macro: lane 1 loaded, err stays 0.
- Zero select and saturation: in_sel=0 with in_valid=1 for 260 consecutive cycles, ECNT_W=8 -> err high throughout, err_cnt stops at 255.
- Reset mid-operation: lanes 0, 3, 5 full, then rst_n=0 for one cycle with in_valid=1 -> out_valid=0, err=0, err_cnt=0, no beat captured.
